// File: rtl/booth_mult_32b.sv
// Iterative radix-2 Booth signed multiplier (32x32 -> low 32 bits plus overflow flag).
// One add/subtract/skip per clock through a single carry-select adder instance.

module CSA_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s
);
  logic [8:0] sum0;
  logic [8:0] sum1;
  logic [8:0] pick;
  logic       c;

  // Four 8-bit blocks; each precomputes both carry cases and the incoming carry selects one.
  always_comb begin
    c    = cin;
    s    = '0;
    sum0 = '0;
    sum1 = '0;
    pick = '0;
    for (int k = 0; k < 4; k++) begin
      sum0 = {1'b0, a[k*8 +: 8]} + {1'b0, b[k*8 +: 8]};
      sum1 = sum0 + 9'd1;
      pick = c ? sum1 : sum0;
      s[k*8 +: 8] = pick[7:0];
      c = pick[8];
    end
  end
endmodule

module booth_mult_32b #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             ctrl_mult,
  output logic             busy,
  output logic             data_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: ctrl_mult is a start request taken in IDLE or DONE; busy covers the
  // iteration window and data_ready pulses for one cycle alongside a held result.
  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic             q_m1;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             v;
  logic             t;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({lo[0], q_m1})
      2'b01: begin add_b = m;  add_cin = 1'b0; end
      2'b10: begin add_b = ~m; add_cin = 1'b1; end
      default: begin add_b = '0; add_cin = 1'b0; end
    endcase
  end

  CSA_32b u_adder (
    .a   (hi),
    .b   (add_b),
    .cin (add_cin),
    .s   (sum)
  );

  // s[31] alone is wrong when the add overflows; t recovers the true 33-bit sign.
  assign v       = (hi[WIDTH-1] == add_b[WIDTH-1]) & (sum[WIDTH-1] != hi[WIDTH-1]);
  assign t       = sum[WIDTH-1] ^ v;
  assign next_hi = {t, sum[WIDTH-1:1]};
  assign next_lo = {sum[0], lo[WIDTH-1:1]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      count          <= '0;
      hi             <= '0;
      lo             <= '0;
      m              <= '0;
      q_m1           <= 1'b0;
      busy           <= 1'b0;
      data_ready     <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          data_ready <= 1'b0;
          if (ctrl_mult) begin
            m     <= data_a;
            hi    <= '0;
            lo    <= data_b;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          hi   <= next_hi;
          lo   <= next_lo;
          q_m1 <= lo[0];
          if (count == CW'(ITER - 1)) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_ready     <= 1'b1;
            data_result    <= next_lo;
            data_exception <= (next_hi != {WIDTH{next_lo[WIDTH-1]}});
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_32b.sv
// Directed and randomized bench for booth_mult_32b against a 64-bit arithmetic product model.

module tb_booth_mult_32b;
  logic        clock;
  logic        resetn;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        ctrl_mult;
  logic        busy;
  logic        data_ready;
  logic [31:0] data_result;
  logic        data_exception;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  booth_mult_32b dut (
    .clock          (clock),
    .resetn         (resetn),
    .data_a         (data_a),
    .data_b         (data_b),
    .ctrl_mult      (ctrl_mult),
    .busy           (busy),
    .data_ready     (data_ready),
    .data_result    (data_result),
    .data_exception (data_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: exact signed product, low word, and whether it fits in signed 32 bits.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] pb;
    logic ovf;
    p   = longint'($signed(a)) * longint'($signed(b));
    pb  = p;
    ovf = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    return {ovf, pb[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Returns at the negedge after the start edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_a = a;
    data_b = b;
    ctrl_mult = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clock);
    @(negedge clock);
    ctrl_mult = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, output int busy_cnt);
    int lat;
    logic [32:0] e;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!data_ready && lat < 40) begin
      cyc();
      lat++;
      if (busy) busy_cnt++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, data_result, e[31:0]);
      chk({tag, "_exception"}, {31'b0, data_exception}, {31'b0, e[32]});
    end
  endtask

  initial begin
    int bc;
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;

    resetn = 1'b0;
    ctrl_mult = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_ready", {31'b0, data_ready}, 32'd0);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'b0, data_exception}, 32'd0);
    resetn = 1'b1;
    cyc();

    start_op(32'd6, 32'd7);
    wait_done("mul_6x7", 32, bc);
    chk("mul_6x7_busy_cycles", 32'(bc), 32'd32);
    chk("mul_6x7_result_const", data_result, 32'h0000002A);
    cyc();
    chk("ready_one_cycle", {31'b0, data_ready}, 32'd0);
    chk("result_held", data_result, 32'h0000002A);

    start_op(32'hFFFFFFFD, 32'd5);           wait_done("neg3x5", 32, bc);
    chk("neg3x5_const", data_result, 32'hFFFFFFF1);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);    wait_done("neg1xneg1", 32, bc);
    start_op(32'h7FFFFFFF, 32'd2);           wait_done("max_x2", 32, bc);
    chk("max_x2_exc_const", {31'b0, data_exception}, 32'd1);
    start_op(32'h00010000, 32'h00010000);    wait_done("p16xp16", 32, bc);
    start_op(32'h80000000, 32'hFFFFFFFF);    wait_done("min_xneg1", 32, bc);
    start_op(32'h80000000, 32'd1);           wait_done("min_x1", 32, bc);
    start_op(32'h80000000, 32'h80000000);    wait_done("min_xmin", 32, bc);

    // Operand change plus a start pulse while iterating must be ignored.
    start_op(32'd6, 32'd7);
    repeat (9) cyc();
    data_a = 32'd9;
    data_b = 32'd11;
    ctrl_mult = 1'b1;
    cyc();
    ctrl_mult = 1'b0;
    wait_done("midrun_ignore", 22, bc);

    // Back-to-back: start request in the DONE cycle.
    data_a = 32'd3;
    data_b = 32'd4;
    ctrl_mult = 1'b1;
    exp_q.push_back(model(32'd3, 32'd4));
    cyc();
    ctrl_mult = 1'b0;
    wait_done("back_to_back", 32, bc);
    chk("back_to_back_const", data_result, 32'h0000000C);

    // Reset mid-run aborts with no pulse.
    start_op(32'd6, 32'd7);
    repeat (14) cyc();
    resetn = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, data_ready}, 32'd0);
    chk("abort_result", data_result, 32'd0);
    chk("abort_exception", {31'b0, data_exception}, 32'd0);
    exp_q.delete();
    repeat (2) cyc();
    resetn = 1'b1;
    pulses = 0;
    repeat (40) begin
      cyc();
      if (data_ready) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    start_op(32'd2, 32'd9);
    wait_done("after_reset_2x9", 32, bc);
    chk("after_reset_const", data_result, 32'h00000012);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'($urandom_range(0, 70000)); rb = 32'($urandom_range(0, 70000)); end
        2: begin ra = 32'h80000000 | 32'($urandom_range(0, 3)); rb = $urandom; end
        default: begin ra = -32'($urandom_range(0, 50000)); rb = 32'($urandom_range(0, 50000)); end
      endcase
      start_op(ra, rb);
      wait_done("random", 32, bc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
